mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported data memory model (DPI-backed, combinational read and write).
- Port 0 is the instruction-fetch unit; port 1 is the load/store unit.
- Accepts one request at a time with valid/ready handshakes and applies a programmable access latency to model real memory timing.
- Drives exactly one memory-enable cycle per transaction, then returns the response through a held valid/ready channel.

Parameters:
- LATENCY, 1: cycles from request acceptance to the memory access cycle. Legal range 1..15.
- AW, 32: address width.
- DW, 32: data width. The strobe width is DW/8.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- m0_req_valid  input  1  port 0 request valid
- m0_req_ready  output  1  port 0 request accepted this cycle
- m0_wr  input  1  port 0 write (1) / read (0)
- m0_addr  input  AW  port 0 address
- m0_wdata  input  DW  port 0 write data
- m0_wstrb  input  DW/8  port 0 byte strobes
- m0_resp_valid  output  1  port 0 response valid
- m0_resp_ready  input  1  port 0 response consumed
- m0_rdata  output  DW  port 0 response data
- m1_*  same nine signals as m0_*, for port 1
- mem_en  output  1  memory enable, one-cycle pulse
- mem_wr  output  1  memory write select
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_wstrb  output  DW/8  memory strobes
- mem_rdata  input  DW  memory data, valid combinationally while mem_en=1

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; last_grant=1, so port 0 wins the first tie.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - Arbitrate over the current-cycle m*_req_valid.
  - If only one port is valid, that port wins.
  - If both are valid, the port not equal to last_grant wins (round-robin).
  - m{g}_req_ready=1 combinationally for the winner only. The loser's ready stays 0.
  - On acceptance, register wr, addr, wdata, wstrb and the grant; update last_grant=g; load counter=LATENCY-1.
  - Next state is ACCESS if LATENCY==1, otherwise WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACCESS. No memory activity and no req_ready in this state.
- ACCESS (exactly one cycle):
  - mem_en=1 and mem_* driven from the registered request.
  - Register mem_rdata into the response buffer for both reads and writes. The write response data is whatever the memory returns; it is not otherwise defined.
  - Go to RESP.
- mem_en and mem_* outputs are 0 in every state except ACCESS.
- RESP:
  - m{g}_resp_valid=1 and m{g}_rdata held stable until m{g}_resp_ready=1.
  - In the handshake cycle, go to IDLE. A new request is accepted in the next IDLE cycle at the earliest.
  - The other port's resp_valid stays 0.
- Timing: a request accepted at cycle T pulses mem_en at T+LATENCY. resp_valid rises at T+LATENCY+1. With resp_ready held high, the minimum issue interval is LATENCY+2 cycles.
- Request signals are sampled only in the acceptance cycle. Changes after acceptance are ignored.
- req_ready never depends on resp_ready. No path from any input to req_ready outside IDLE.
- m*_rdata is 0 except while the corresponding resp_valid=1.
- Reset asserted mid-transaction:
  - All state clears immediately and the transaction is dropped.
  - If reset hits in WAIT, no mem_en is issued.
  - If reset hits in RESP, the response is lost and resp_valid drops asynchronously.
- No outstanding-transaction queue. Only one transaction is in flight at a time.

Test Plan:
- Single read, LATENCY=1: m0 reads addr 0x80000000, mem returns 0x00000413. Expect m0_req_ready at T, mem_en=1 with mem_wr=0 and addr 0x80000000 at T+1 only, m0_resp_valid at T+2 with rdata=0x00000413.
- Write from port 1: wr=1, addr 0x80001000, wdata 0xDEADBEEF, wstrb 0x3. Expect exactly one mem_en cycle carrying those values with mem_wstrb=0x3. m1_resp_valid follows; m0 sees nothing.
- Contention: both ports valid from reset. Grants go m0, m1, m0, m1 across four transactions. The loser's req_ready stays 0 until it is granted.
- Backpressure: hold m0_resp_ready=0 for 5 cycles. resp_valid and rdata stay stable. No new req_ready for either port. After ready=1, return to IDLE.
- LATENCY=4: accept at T. mem_en only at T+4; resp_valid at T+5. Changing m0_addr during WAIT does not change mem_addr.
- Reset in WAIT (LATENCY=3): deassert rst_n at T+1. No mem_en occurs. All outputs are 0 immediately. After release, a fresh m1 request is accepted normally, and port 0 wins the first tie.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and memory bus bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            m0_req_valid;
  logic            m0_req_ready;
  logic            m0_wr;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wdata;
  logic [DW/8-1:0] m0_wstrb;
  logic            m0_resp_valid;
  logic            m0_resp_ready;
  logic [DW-1:0]   m0_rdata;

  logic            m1_req_valid;
  logic            m1_req_ready;
  logic            m1_wr;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wstrb;
  logic            m1_resp_valid;
  logic            m1_resp_ready;
  logic [DW-1:0]   m1_rdata;

  logic            mem_en;
  logic            mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  m0_req_valid, m0_wr, m0_addr, m0_wdata, m0_wstrb, m0_resp_ready,
    input  m1_req_valid, m1_wr, m1_addr, m1_wdata, m1_wstrb, m1_resp_ready,
    input  mem_rdata,
    output m0_req_ready, m0_resp_valid, m0_rdata,
    output m1_req_ready, m1_resp_valid, m1_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output m0_req_valid, m0_wr, m0_addr, m0_wdata, m0_wstrb, m0_resp_ready,
    output m1_req_valid, m1_wr, m1_addr, m1_wdata, m1_wstrb, m1_resp_ready,
    output mem_rdata,
    input  m0_req_ready, m0_resp_valid, m0_rdata,
    input  m1_req_ready, m1_resp_valid, m1_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-ported memory:
// one transaction in flight, programmable access latency, held response channel.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int unsigned SW       = DW / 8;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q, grant_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;

    bus.m0_req_ready  = 1'b0;
    bus.m1_req_ready  = 1'b0;
    bus.m0_resp_valid = 1'b0;
    bus.m1_resp_valid = 1'b0;
    bus.m0_rdata      = '0;
    bus.m1_rdata      = '0;
    bus.mem_en        = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_wstrb     = '0;

    // Port 1 wins alone, or on a tie when port 0 was granted last.
    win1 = bus.m1_req_valid && (!bus.m0_req_valid || !last_grant_q);

    case (state_q)
      S_IDLE: begin
        // Masked by rst_n so every output reads 0 while reset is held.
        bus.m0_req_ready = rst_n && bus.m0_req_valid && !win1;
        bus.m1_req_ready = rst_n && win1;
        if (bus.m0_req_valid || bus.m1_req_valid) begin
          grant_d      = win1;
          last_grant_d = win1;
          wr_d         = win1 ? bus.m1_wr    : bus.m0_wr;
          addr_d       = win1 ? bus.m1_addr  : bus.m0_addr;
          wdata_d      = win1 ? bus.m1_wdata : bus.m0_wdata;
          wstrb_d      = win1 ? bus.m1_wstrb : bus.m0_wstrb;
          cnt_d        = CNT_LOAD;
          state_d      = (LATENCY == 1) ? S_ACCESS : S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end

      S_ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = wr_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wstrb = wstrb_q;
        rdata_d       = bus.mem_rdata;
        state_d       = S_RESP;
      end

      S_RESP: begin
        if (grant_q) begin
          bus.m1_resp_valid = 1'b1;
          bus.m1_rdata      = rdata_q;
          if (bus.m1_resp_ready) state_d = S_IDLE;
        end else begin
          bus.m0_resp_valid = 1'b1;
          bus.m0_rdata      = rdata_q;
          if (bus.m0_resp_ready) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (LATENCY 1, 4, 3) share stimulus,
// only the instance under test is out of reset; a negedge monitor checks memory and response traffic.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst1_n, rst4_n, rst3_n;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(32), .DW(32)) i1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) i4 ();
  mem_arbiter_if #(.AW(32), .DW(32)) i3 ();

  mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_d1 (.clk(clk), .rst_n(rst1_n), .bus(i1.slave));
  mem_arbiter #(.LATENCY(4), .AW(32), .DW(32)) u_d4 (.clk(clk), .rst_n(rst4_n), .bus(i4.slave));
  mem_arbiter #(.LATENCY(3), .AW(32), .DW(32)) u_d3 (.clk(clk), .rst_n(rst3_n), .bus(i3.slave));

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_9BDF);
  endfunction

  assign i1.mem_rdata = i1.mem_en ? mem_model(i1.mem_addr) : 32'hBADB_AD00;
  assign i4.mem_rdata = i4.mem_en ? mem_model(i4.mem_addr) : 32'hBADB_AD00;
  assign i3.mem_rdata = i3.mem_en ? mem_model(i3.mem_addr) : 32'hBADB_AD00;

  // Stimulus is written to i1 and mirrored to the other two instances.
  always_comb begin
    i4.m0_req_valid = i1.m0_req_valid;  i3.m0_req_valid = i1.m0_req_valid;
    i4.m0_wr        = i1.m0_wr;         i3.m0_wr        = i1.m0_wr;
    i4.m0_addr      = i1.m0_addr;       i3.m0_addr      = i1.m0_addr;
    i4.m0_wdata     = i1.m0_wdata;      i3.m0_wdata     = i1.m0_wdata;
    i4.m0_wstrb     = i1.m0_wstrb;      i3.m0_wstrb     = i1.m0_wstrb;
    i4.m0_resp_ready = i1.m0_resp_ready; i3.m0_resp_ready = i1.m0_resp_ready;
    i4.m1_req_valid = i1.m1_req_valid;  i3.m1_req_valid = i1.m1_req_valid;
    i4.m1_wr        = i1.m1_wr;         i3.m1_wr        = i1.m1_wr;
    i4.m1_addr      = i1.m1_addr;       i3.m1_addr      = i1.m1_addr;
    i4.m1_wdata     = i1.m1_wdata;      i3.m1_wdata     = i1.m1_wdata;
    i4.m1_wstrb     = i1.m1_wstrb;      i3.m1_wstrb     = i1.m1_wstrb;
    i4.m1_resp_ready = i1.m1_resp_ready; i3.m1_resp_ready = i1.m1_resp_ready;
  end

  typedef struct packed {
    logic        r0, r1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        en, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
  } obs_t;

  obs_t obs [3];

  always_comb begin
    obs[0] = {i1.m0_req_ready, i1.m1_req_ready, i1.m0_resp_valid, i1.m1_resp_valid, i1.m0_rdata,
              i1.m1_rdata, i1.mem_en, i1.mem_wr, i1.mem_addr, i1.mem_wdata, i1.mem_wstrb};
    obs[1] = {i4.m0_req_ready, i4.m1_req_ready, i4.m0_resp_valid, i4.m1_resp_valid, i4.m0_rdata,
              i4.m1_rdata, i4.mem_en, i4.mem_wr, i4.mem_addr, i4.mem_wdata, i4.mem_wstrb};
    obs[2] = {i3.m0_req_ready, i3.m1_req_ready, i3.m0_resp_valid, i3.m1_resp_valid, i3.m0_rdata,
              i3.m1_rdata, i3.mem_en, i3.mem_wr, i3.mem_addr, i3.mem_wdata, i3.mem_wstrb};
  end

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] cyc;
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
  } mem_exp_t;

  typedef struct packed {
    logic [1:0]  dut;
    logic        port;
    logic [31:0] cyc;
    logic [31:0] rdata;
  } resp_exp_t;

  mem_exp_t  memq[$];
  resp_exp_t respq[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected memory cycle and response for a request accepted at cycle t_acc.
  task automatic exp_txn(input int d, input bit p, input int unsigned t_acc, input int unsigned lat,
                         input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    memq.push_back('{dut: 2'(d), cyc: t_acc + lat, wr: wr, addr: a, wdata: wd, wstrb: ws});
    respq.push_back('{dut: 2'(d), port: p, cyc: t_acc + lat + 1, rdata: mem_model(a)});
  endtask

  task automatic req(input bit p, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws);
    if (!p) begin
      i1.m0_wr = wr; i1.m0_addr = a; i1.m0_wdata = wd; i1.m0_wstrb = ws; i1.m0_req_valid = 1'b1;
    end else begin
      i1.m1_wr = wr; i1.m1_addr = a; i1.m1_wdata = wd; i1.m1_wstrb = ws; i1.m1_req_valid = 1'b1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every mem_en and on every rising resp_valid.
  logic        prev_rv [3][2];
  logic [31:0] held    [3][2];

  initial begin
    for (int d = 0; d < 3; d++) begin
      prev_rv[d][0] = 1'b0;
      prev_rv[d][1] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      mem_exp_t  m_got;
      resp_exp_t r_got;
      logic        rv;
      logic [31:0] rd;
      m_got = '{dut: 2'(d), cyc: cyc, wr: obs[d].wr, addr: obs[d].addr, wdata: obs[d].wdata,
                wstrb: obs[d].wstrb};
      if (obs[d].en) begin
        if (memq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_unexpected: got %0h expected no access", m_got);
        end else begin
          chk("mem_access", 160'(m_got), 160'(memq.pop_front()));
        end
      end else begin
        chk("mem_idle_zero", 160'({obs[d].wr, obs[d].addr, obs[d].wdata, obs[d].wstrb}), '0);
      end
      for (int p = 0; p < 2; p++) begin
        rv = (p == 0) ? obs[d].rv0 : obs[d].rv1;
        rd = (p == 0) ? obs[d].rd0 : obs[d].rd1;
        r_got = '{dut: 2'(d), port: p[0], cyc: cyc, rdata: rd};
        if (rv && !prev_rv[d][p]) begin
          held[d][p] = rd;
          if (respq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_unexpected: got %0h expected no response", r_got);
          end else begin
            chk("resp", 160'(r_got), 160'(respq.pop_front()));
          end
        end else if (rv) begin
          chk("resp_hold", 160'(rd), 160'(held[d][p]));
        end else begin
          chk("rdata_zero", 160'(rd), '0);
        end
        prev_rv[d][p] = rv;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [1:0] rr_tab [10] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
  logic [2:0] bp_tab [12] = '{3'b001, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100,
                              3'b100, 3'b100, 3'b010, 3'b000, 3'b000, 3'b001};
  logic [2:0] l4_tab [7]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000};
  logic [1:0] rs_tab [7]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};

  initial begin
    int unsigned t;
    rst1_n = 1'b0; rst4_n = 1'b0; rst3_n = 1'b0;
    i1.m0_req_valid = 1'b0; i1.m0_wr = 1'b0; i1.m0_addr = '0; i1.m0_wdata = '0; i1.m0_wstrb = '0;
    i1.m1_req_valid = 1'b0; i1.m1_wr = 1'b0; i1.m1_addr = '0; i1.m1_wdata = '0; i1.m1_wstrb = '0;
    i1.m0_resp_ready = 1'b1; i1.m1_resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("reset_state", 160'(obs[d]), '0);
    next_cycle();

    // Contention from reset on LATENCY=1: grants m0, m1, m0, m1.
    rst1_n = 1'b1;
    req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    req(1, 1'b1, 32'h8000_0030, 32'h1122_3344, 4'hF);
    t = cyc;
    exp_txn(0, 0, t,     1, 1'b0, 32'h8000_0010, 32'h0,         4'h0);
    exp_txn(0, 1, t + 3, 1, 1'b1, 32'h8000_0030, 32'h1122_3344, 4'hF);
    exp_txn(0, 0, t + 6, 1, 1'b0, 32'h8000_0020, 32'h0,         4'h0);
    exp_txn(0, 1, t + 9, 1, 1'b0, 32'h8000_0040, 32'h0,         4'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 10) chk("rr_ready", 160'({obs[0].r1, obs[0].r0}), 160'(rr_tab[i]));
      next_cycle();
      case (i + 1)
        1:  i1.m0_addr = 32'h8000_0020;
        4:  begin i1.m1_addr = 32'h8000_0040; i1.m1_wr = 1'b0; i1.m1_wdata = '0; i1.m1_wstrb = '0; end
        7:  i1.m0_req_valid = 1'b0;
        10: i1.m1_req_valid = 1'b0;
        default: ;
      endcase
    end

    // Single read from port 0.
    req(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    t = cyc;
    exp_txn(0, 0, t, 1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd_ready", 160'({obs[0].r1, obs[0].r0}), 160'(2'b01));
    next_cycle();
    i1.m0_req_valid = 1'b0;
    @(negedge clk);
    chk("rd_mem", 160'({obs[0].en, obs[0].wr, obs[0].addr}), 160'({1'b1, 1'b0, 32'h8000_0000}));
    next_cycle();
    @(negedge clk);
    chk("rd_resp", 160'({obs[0].rv0, obs[0].rd0}), 160'({1'b1, 32'h0000_0413}));
    repeat (2) next_cycle();

    // Write from port 1.
    req(1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3);
    t = cyc;
    exp_txn(0, 1, t, 1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3);
    @(negedge clk);
    chk("wr_ready", 160'({obs[0].r1, obs[0].r0}), 160'(2'b10));
    next_cycle();
    i1.m1_req_valid = 1'b0;
    repeat (3) next_cycle();

    // Backpressure on port 0 for 5 cycles with both ports requesting meanwhile.
    i1.m0_resp_ready = 1'b0;
    req(0, 1'b0, 32'h8000_0040, 32'h0, 4'h0);
    t = cyc;
    exp_txn(0, 0, t,      1, 1'b0, 32'h8000_0040, 32'h0, 4'h0);
    exp_txn(0, 1, t + 8,  1, 1'b0, 32'h8000_0100, 32'h0, 4'h0);
    exp_txn(0, 0, t + 11, 1, 1'b0, 32'h8000_0080, 32'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("bp_ctrl", 160'({obs[0].rv0, obs[0].r1, obs[0].r0}), 160'(bp_tab[i]));
      next_cycle();
      case (i + 1)
        1:  begin i1.m0_addr = 32'h8000_0080; req(1, 1'b0, 32'h8000_0100, 32'h0, 4'h0); end
        7:  i1.m0_resp_ready = 1'b1;
        9:  i1.m1_req_valid = 1'b0;
        12: i1.m0_req_valid = 1'b0;
        default: ;
      endcase
    end
    repeat (3) next_cycle();

    // LATENCY=4: address changes during WAIT must not reach the memory.
    rst1_n = 1'b0;
    rst4_n = 1'b1;
    req(0, 1'b0, 32'h8000_2000, 32'h0, 4'h0);
    t = cyc;
    exp_txn(1, 0, t, 4, 1'b0, 32'h8000_2000, 32'h0, 4'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("lat4_ctrl", 160'({obs[1].rv0, obs[1].en, obs[1].r0}), 160'(l4_tab[i]));
      if (i == 4) chk("lat4_addr", 160'(obs[1].addr), 160'(32'h8000_2000));
      next_cycle();
      case (i + 1)
        1: i1.m0_addr = 32'h8000_2FFC;
        2: i1.m0_addr = 32'h8000_2AA0;
        3: i1.m0_req_valid = 1'b0;
        default: ;
      endcase
    end
    repeat (2) next_cycle();

    // LATENCY=3: reset hits in WAIT, transaction is dropped.
    rst4_n = 1'b0;
    rst3_n = 1'b1;
    req(0, 1'b0, 32'h8000_3000, 32'h0, 4'h0);
    @(negedge clk);
    chk("rst_pre_ready", 160'(obs[2].r0), 160'(1'b1));
    next_cycle();
    #2 rst3_n = 1'b0;
    #1 chk("rst_async_zero", 160'(obs[2]), '0);
    i1.m0_req_valid = 1'b0;
    repeat (5) next_cycle();
    rst3_n = 1'b1;
    req(0, 1'b0, 32'h8000_3100, 32'h0, 4'h0);
    req(1, 1'b0, 32'h8000_3200, 32'h0, 4'h0);
    t = cyc;
    exp_txn(2, 0, t,     3, 1'b0, 32'h8000_3100, 32'h0, 4'h0);
    exp_txn(2, 1, t + 5, 3, 1'b0, 32'h8000_3200, 32'h0, 4'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("rst_after_ready", 160'({obs[2].r1, obs[2].r0}), 160'(rs_tab[i]));
      next_cycle();
      case (i + 1)
        1: i1.m0_req_valid = 1'b0;
        6: i1.m1_req_valid = 1'b0;
        default: ;
      endcase
    end
    repeat (4) next_cycle();

    chk("scoreboard_empty", 160'({memq.size(), respq.size()}), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
